// File: rtl/irq_pending_latch.sv
// Edge-triggered 16-source interrupt pending latch with ack/timeout FSM.
// Optional macro IRQ_INPUT_SYNC_EN adds a two-flop synchronizer on req.
module irq_pending_latch #(
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   input  logic [15:0] mask,
   output logic [15:0] pend,
   output logic        irq,
   input  logic        ack,
   input  logic [3:0]  ack_idx,
   output logic        err,
   output logic        timeout
);

   localparam int unsigned NREQ = 16;
   localparam int unsigned CW   = 8;
   localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_GAP} state_e;

   logic [NREQ-1:0] req_s;
   logic [NREQ-1:0] req_prev_q, req_prev_d;
   logic [NREQ-1:0] p_q, p_d;
   logic [NREQ-1:0] rise, clr_mask;
   logic [CW-1:0]   cnt_q, cnt_d;
   state_e          state_q, state_d;
   logic            irq_q, irq_d;
   logic            err_q, err_d;
   logic            timeout_q, timeout_d;
   logic            ack_legal;

`ifdef IRQ_INPUT_SYNC_EN
   logic [NREQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

   always_comb begin
      sync1_d = req;
      sync2_d = sync1_q;
   end

   // Reset to ones so lines high at reset release never look like edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign req_s = sync2_q;
`else
   assign req_s = req;
`endif

   assign pend = p_q & mask;

   always_comb begin
      rise       = req_s & ~req_prev_q;
      req_prev_d = req_s;
      ack_legal  = ack && (state_q == ST_ACTIVE) && pend[ack_idx];
      clr_mask   = ack_legal ? (NREQ'(1) << ack_idx) : '0;
      // Set is OR-ed after the clear so a same-cycle edge wins.
      p_d        = (p_q & ~clr_mask) | rise;

      state_d    = state_q;
      cnt_d      = cnt_q;
      timeout_d  = 1'b0;
      err_d      = ack && !ack_legal;

      unique case (state_q)
         ST_IDLE: begin
            if (|pend) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
            end
         end
         ST_ACTIVE: begin
            if (ack_legal) begin
               state_d = ST_GAP;
            end else if (!(|pend)) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_MAX) begin
               // An illegal ack at expiry defers the timeout so err and timeout never coincide.
               if (!ack) begin
                  state_d   = ST_GAP;
                  timeout_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_GAP: begin
            if (|pend) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      irq_d = (state_d == ST_ACTIVE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_prev_q <= '1;
         p_q        <= '0;
         cnt_q      <= '0;
         state_q    <= ST_IDLE;
         irq_q      <= 1'b0;
         err_q      <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         req_prev_q <= req_prev_d;
         p_q        <= p_d;
         cnt_q      <= cnt_d;
         state_q    <= state_d;
         irq_q      <= irq_d;
         err_q      <= err_d;
         timeout_q  <= timeout_d;
      end
   end

   assign irq     = irq_q;
   assign err     = err_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Self-checking bench for irq_pending_latch: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_irq_pending_latch;

   localparam int TO = 4;
`ifdef IRQ_INPUT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] req, mask, pend;
   logic        irq, ack, err, timeout;
   logic [3:0]  ack_idx;

   int checks = 0;
   int errors = 0;

   irq_pending_latch #(.ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .pend(pend), .irq(irq),
      .ack(ack), .ack_idx(ack_idx), .err(err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Behavioural model: pending set, sampled history, and an "interrupt phase".
   logic [15:0] m_p, m_prev, m_s1, m_s2;
   int          m_mode;   // 0 quiet, 1 asserted, 2 one-cycle gap
   int          m_age;
   bit          m_err, m_to;

   function automatic logic [15:0] m_pend();
      return m_p & mask;
   endfunction

   task automatic model_reset();
      m_p = '0; m_prev = '1; m_s1 = '1; m_s2 = '1;
      m_mode = 0; m_age = 0; m_err = 0; m_to = 0;
   endtask

   task automatic model_edge();
      logic [15:0] seen, rise, pn;
      bit legal;
`ifdef IRQ_INPUT_SYNC_EN
      seen = m_s2; m_s2 = m_s1; m_s1 = req;
`else
      seen = req;
`endif
      rise   = seen & ~m_prev;
      m_prev = seen;
      pn     = m_p & mask;
      legal  = ack && (m_mode == 1) && (pn[ack_idx] == 1'b1);
      m_err  = ack && !legal;
      m_to   = 0;
      if (m_mode == 0) begin
         if (pn != 0) begin m_mode = 1; m_age = 0; end
      end else if (m_mode == 1) begin
         if (legal) m_mode = 2;
         else if (pn == 0) m_mode = 0;
         else if (m_age >= TO - 1) begin
            if (!ack) begin m_mode = 2; m_to = 1; end
         end else m_age++;
      end else begin
         if (pn != 0) begin m_mode = 1; m_age = 0; end
         else m_mode = 0;
      end
      if (legal) m_p[ack_idx] = 1'b0;
      m_p = m_p | rise;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; mask = '1; ack = 1'b0; ack_idx = '0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) tick();
   endtask

   task automatic pulse_ack(input logic [3:0] idx);
      ack = 1'b1; ack_idx = idx;
      tick();
      ack = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({pend, irq, err, timeout} !== 19'd0) begin
         errors++;
         $display("FAIL reset_state got %h/%b/%b/%b exp 0000/0/0/0", pend, irq, err, timeout);
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 16'h0100;
      repeat (LAT) tick();
      checks++;
      if (pend !== 16'h0100 || irq !== 1'b0) begin
         errors++; $display("FAIL single_pend got %h irq %b exp 0100 irq 0", pend, irq);
      end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL single_irq got %b exp 1", irq); end
      pulse_ack(4'd8);
      checks++;
      if (pend !== 16'h0000 || irq !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL single_ack got %h irq %b err %b exp 0000 0 0", pend, irq, err);
      end
      repeat (3) tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL single_stay_low got %b exp 0", irq); end
   endtask

   task automatic test_two_bits();
      do_reset();
      req = 16'h8008;
      repeat (LAT + 1) tick();
      checks++;
      if (pend !== 16'h8008 || irq !== 1'b1) begin
         errors++; $display("FAIL two_pend got %h irq %b exp 8008 1", pend, irq);
      end
      pulse_ack(4'd15);
      checks++;
      if (pend !== 16'h0008 || irq !== 1'b0) begin
         errors++; $display("FAIL two_gap got %h irq %b exp 0008 0", pend, irq);
      end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL two_reassert got %b exp 1", irq); end
      pulse_ack(4'd3);
      checks++;
      if (pend !== 16'h0000 || irq !== 1'b0) begin
         errors++; $display("FAIL two_clear got %h irq %b exp 0000 0", pend, irq);
      end
      tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL two_idle got %b exp 0", irq); end
   endtask

   task automatic test_timeout();
      do_reset();
      req = 16'h0001;
      repeat (LAT) tick();
      for (int k = 0; k < TO; k++) begin
         tick();
         checks++;
         if (irq !== 1'b1 || timeout !== 1'b0) begin
            errors++; $display("FAIL to_active[%0d] irq %b to %b exp 1 0", k, irq, timeout);
         end
      end
      tick();
      checks++;
      if (irq !== 1'b0 || timeout !== 1'b1 || pend !== 16'h0001) begin
         errors++; $display("FAIL to_pulse irq %b to %b pend %h exp 0 1 0001", irq, timeout, pend);
      end
      tick();
      checks++;
      if (irq !== 1'b1 || timeout !== 1'b0) begin
         errors++; $display("FAIL to_rearm irq %b to %b exp 1 0", irq, timeout);
      end
   endtask

   task automatic test_err();
      do_reset();
      req = 16'h0001;
      repeat (LAT + 1) tick();
      pulse_ack(4'd5);
      checks++;
      if (err !== 1'b1 || pend !== 16'h0001 || irq !== 1'b1) begin
         errors++; $display("FAIL err_badidx err %b pend %h irq %b exp 1 0001 1", err, pend, irq);
      end
      pulse_ack(4'd0);
      checks++;
      if (err !== 1'b0 || pend !== 16'h0000) begin
         errors++; $display("FAIL err_goodack err %b pend %h exp 0 0000", err, pend);
      end
      tick();
      pulse_ack(4'd0);
      checks++;
      if (err !== 1'b1 || irq !== 1'b0 || pend !== 16'h0000) begin
         errors++; $display("FAIL err_idle err %b irq %b pend %h exp 1 0 0000", err, irq, pend);
      end
      tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_oneshot got %b exp 0", err); end
   endtask

   task automatic test_mask();
      do_reset();
      req = 16'h0004;
      repeat (LAT + 1) tick();
      mask = 16'hFFFB;
      #1;
      checks++;
      if (pend !== 16'h0000) begin errors++; $display("FAIL mask_comb got %h exp 0000", pend); end
      tick();
      checks++;
      if (irq !== 1'b0 || err !== 1'b0 || timeout !== 1'b0) begin
         errors++; $display("FAIL mask_idle irq %b err %b to %b exp 0 0 0", irq, err, timeout);
      end
      mask = 16'hFFFF;
      #1;
      checks++;
      if (pend !== 16'h0004) begin errors++; $display("FAIL mask_restore got %h exp 0004", pend); end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL mask_reassert got %b exp 1", irq); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 16'hF000;
      repeat (LAT + 1) tick();
      checks++;
      if (pend !== 16'hF000 || irq !== 1'b1) begin
         errors++; $display("FAIL rmid_pre pend %h irq %b exp f000 1", pend, irq);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({pend, irq, err, timeout} !== 19'd0) begin
         errors++; $display("FAIL rmid_async got %h/%b/%b/%b exp 0000/0/0/0", pend, irq, err, timeout);
      end
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if (pend !== 16'h0000 || irq !== 1'b0 || err !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL rmid_hold[%0d] pend %h irq %b exp 0000 0", k, pend, irq);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] pn;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         req = req ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
         if ($urandom_range(0, 19) == 0) mask = 16'($urandom);
         else if ($urandom_range(0, 9) == 0) mask = 16'hFFFF;
         ack = ($urandom_range(0, 9) < 3);
         ack_idx = 4'($urandom);
         pn = m_pend();
         if ($urandom_range(0, 1) == 1 && pn != 0) begin
            for (int b = 15; b >= 0; b--) if (pn[b]) ack_idx = 4'(b);
         end
         tick();
         ack = 1'b0;
         checks++;
         if (pend !== m_pend() || irq !== (m_mode == 1) || err !== m_err || timeout !== m_to) begin
            errors++;
            $display("FAIL rand[%0d] got %h/%b/%b/%b exp %h/%b/%b/%b", c, pend, irq, err, timeout,
                     m_pend(), (m_mode == 1), m_err, m_to);
         end
         checks++;
         if (err === 1'b1 && timeout === 1'b1) begin
            errors++; $display("FAIL rand_exclusive[%0d] err %b to %b exp not both", c, err, timeout);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; req = '0; mask = '1; ack = 1'b0; ack_idx = '0;
      model_reset();
      test_reset();
      test_single();
      test_two_bits();
      test_timeout();
      test_err();
      test_mask();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
